// File: rtl/lcd_write_arbiter.sv
// Round-robin arbiter sharing one LCD serial-write engine between drawing clients.
// A grant is held for a whole transaction, then a fixed idle gap precedes the next grant.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no grant; waiting for init_done and a pending request
// ST_GRANT | one client owns the engine; watchdog running
// ST_GAP   | grant dropped; counting GAP_CYCLES before the next grant
module lcd_write_arbiter #(
    parameter int NUM_CLIENTS = 3,
    parameter int GAP_CYCLES  = 4,
    parameter int TIMEOUT     = 65535
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     init_done,
    input  logic [NUM_CLIENTS-1:0]   req_en,
    input  logic [9*NUM_CLIENTS-1:0] req_data,
    input  logic [NUM_CLIENTS-1:0]   req_done,
    output logic [NUM_CLIENTS-1:0]   grant,
    output logic [NUM_CLIENTS-1:0]   client_wr_done,
    output logic [8:0]               lcd_data,
    output logic                     lcd_en_write,
    input  logic                     lcd_wr_done,
    output logic                     busy,
    output logic                     timeout_err,
    input  logic                     err_clr
);

    localparam int IDXW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);
    localparam logic [3:0]  GAP_LAST = 4'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_CLIENTS-1:0] grant_q, grant_d;
    logic [IDXW-1:0]        gidx_q, gidx_d;
    logic [IDXW-1:0]        last_q, last_d;
    logic [3:0]             gap_q, gap_d;
    logic [15:0]            wd_q, wd_d;
    logic                   err_q, err_d;

    logic                   pick_vld;
    logic [IDXW-1:0]        pick_idx;
    logic [NUM_CLIENTS-1:0] pick_onehot;
    logic                   g_en;
    logic                   g_done;
    logic [8:0]             g_data;
    logic                   in_grant;

    // Scan from the client after the last owner, wrapping around.
    always_comb begin
        int idx;
        idx         = 0;
        pick_vld    = 1'b0;
        pick_idx    = last_q;
        pick_onehot = '0;
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            idx = (int'(last_q) + k) % NUM_CLIENTS;
            if (!pick_vld && req_en[idx]) begin
                pick_vld = 1'b1;
                pick_idx = IDXW'(idx);
            end
        end
        pick_onehot[pick_idx] = 1'b1;
    end

    always_comb begin
        g_en   = req_en[gidx_q];
        g_done = req_done[gidx_q];
        g_data = req_data[int'(gidx_q)*9 +: 9];
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IDXW'(NUM_CLIENTS - 1);
            gap_q   <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        gap_d   = gap_q;
        wd_d    = '0;
        err_d   = err_clr ? 1'b0 : err_q;

        case (state_q)
            ST_IDLE: begin
                if (init_done && pick_vld) begin
                    state_d = ST_GRANT;
                    grant_d = pick_onehot;
                    gidx_d  = pick_idx;
                end
            end

            ST_GRANT: begin
                if (g_done || !g_en || (wd_q >= WD_LIMIT)) begin
                    state_d = ST_GAP;
                    grant_d = '0;
                    last_d  = gidx_q;
                    gap_d   = '0;
                    if (!g_done && g_en) begin
                        err_d = 1'b1;
                    end
                end else if (lcd_wr_done) begin
                    wd_d = '0;
                end else if (wd_q != 16'hFFFF) begin
                    wd_d = wd_q + 16'd1;
                end else begin
                    wd_d = wd_q;
                end
            end

            ST_GAP: begin
                // The last gap cycle arbitrates directly, so a pending request
                // sees exactly GAP_CYCLES grant-free cycles.
                if (gap_q >= GAP_LAST) begin
                    gap_d = '0;
                    if (init_done && pick_vld) begin
                        state_d = ST_GRANT;
                        grant_d = pick_onehot;
                        gidx_d  = pick_idx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign in_grant       = (state_q == ST_GRANT) && !sys_rst;
    assign grant          = grant_q;
    assign busy           = (state_q != ST_IDLE);
    assign timeout_err    = err_q;
    assign lcd_en_write   = in_grant && g_en;
    assign lcd_data       = in_grant ? g_data : 9'd0;
    assign client_wr_done = (in_grant && lcd_wr_done) ? grant_q : '0;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed bench for lcd_write_arbiter: grant latency, round robin, gap length,
// init gating, watchdog, wr_done isolation and async reset.
module tb_lcd_write_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        init_done;
    logic [2:0]  req_en;
    logic [26:0] req_data;
    logic [2:0]  req_done;
    logic [2:0]  grant;
    logic [2:0]  client_wr_done;
    logic [8:0]  lcd_data;
    logic        lcd_en_write;
    logic        lcd_wr_done;
    logic        busy;
    logic        timeout_err;
    logic        err_clr;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 sys_clk = ~sys_clk;

    lcd_write_arbiter #(
        .NUM_CLIENTS(3),
        .GAP_CYCLES (4),
        .TIMEOUT    (16)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .init_done     (init_done),
        .req_en        (req_en),
        .req_data      (req_data),
        .req_done      (req_done),
        .grant         (grant),
        .client_wr_done(client_wr_done),
        .lcd_data      (lcd_data),
        .lcd_en_write  (lcd_en_write),
        .lcd_wr_done   (lcd_wr_done),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .err_clr       (err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_data(input int c, input logic [8:0] v);
        req_data[c*9 +: 9] = v;
    endtask

    task automatic wait_grant(output int cycles);
        cycles = 0;
        while (grant == 3'b000 && cycles < 50) begin
            tick();
            cycles++;
        end
    endtask

    task automatic do_reset();
        sys_rst     = 1'b1;
        req_en      = '0;
        req_done    = '0;
        lcd_wr_done = 1'b0;
        err_clr     = 1'b0;
        tick();
        tick();
        sys_rst = 1'b0;
    endtask

    initial begin
        logic [2:0] rr_exp [4];
        int pulses, bad, cyc, n;

        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
        sys_rst = 1'b1; init_done = 1'b0; req_en = '0; req_data = '0;
        req_done = '0; lcd_wr_done = 1'b0; err_clr = 1'b0;
        #3;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(timeout_err), 32'd0);
        chk("rst_en", 32'(lcd_en_write), 32'd0);
        tick();
        tick();
        sys_rst = 1'b0;

        // single request: latency, data path, wr_done routing, gap length
        init_done = 1'b1;
        set_data(1, 9'h1FF);
        set_data(2, 9'h0AA);
        set_data(0, 9'h100);
        req_en = 3'b001;
        tick();
        chk("t1_latency", 32'(grant), 32'h1);
        chk("t1_busy", 32'(busy), 32'd1);
        pulses = 0;
        bad    = 0;
        for (int i = 0; i < 10; i++) begin
            set_data(0, 9'(9'h100 + i));
            lcd_wr_done = 1'b1;
            #1;
            if (client_wr_done == 3'b001) pulses++;
            if (lcd_data != 9'(9'h100 + i) || !lcd_en_write) bad++;
            tick();
            lcd_wr_done = 1'b0;
            tick();
        end
        chk("t1_pulses", 32'(pulses), 32'd10);
        chk("t1_data_errors", 32'(bad), 32'd0);
        req_done = 3'b001;
        tick();
        req_done = 3'b000;
        req_en   = 3'b000;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (grant == 3'b000 && busy) n++;
            tick();
        end
        chk("t1_gap_cycles", 32'(n), 32'd4);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // round robin from reset
        do_reset();
        req_en = 3'b111;
        for (int r = 0; r < 4; r++) begin
            wait_grant(cyc);
            chk("t2_order", 32'(grant), 32'(rr_exp[r]));
            if (r == 0) chk("t2_latency", 32'(cyc), 32'd1);
            else chk("t2_gap", 32'(cyc), 32'd4);
            for (int w = 0; w < 5; w++) begin
                lcd_wr_done = 1'b1;
                tick();
                lcd_wr_done = 1'b0;
                tick();
            end
            req_done = rr_exp[r];
            tick();
            req_done = 3'b000;
            chk("t2_release", 32'(grant), 32'd0);
            if (r == 3) chk("t2_gap_en", 32'(lcd_en_write), 32'd0);
        end
        req_en = 3'b000;
        repeat (6) tick();
        chk("t2_idle", 32'(busy), 32'd0);

        // init gating
        init_done = 1'b0;
        req_en    = 3'b010;
        bad = 0;
        repeat (20) begin
            tick();
            if (grant != 3'b000) bad++;
        end
        chk("t3_gated", 32'(bad), 32'd0);
        init_done = 1'b1;
        tick();
        chk("t3_grant", 32'(grant), 32'h2);
        req_en = 3'b000;
        repeat (7) tick();

        // watchdog on client 2
        req_en = 3'b100;
        tick();
        chk("t4_grant", 32'(grant), 32'h4);
        n = 0;
        while (grant == 3'b100 && n < 40) begin
            n++;
            tick();
        end
        req_en = 3'b000;
        chk("t4_grant_len", 32'(n), 32'd16);
        chk("t4_err_set", 32'(timeout_err), 32'd1);
        repeat (8) tick();
        chk("t4_err_sticky", 32'(timeout_err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t4_err_clr", 32'(timeout_err), 32'd0);

        // req_done coinciding with the watchdog limit is a normal release
        req_en = 3'b001;
        tick();
        repeat (15) tick();
        chk("t4b_held", 32'(grant), 32'h1);
        req_done = 3'b001;
        tick();
        req_done = 3'b000;
        req_en   = 3'b000;
        chk("t4b_release", 32'(grant), 32'd0);
        chk("t4b_no_err", 32'(timeout_err), 32'd0);
        repeat (6) tick();

        // isolation of data path and wr_done routing
        req_en = 3'b001;
        tick();
        chk("t5_grant", 32'(grant), 32'h1);
        req_en = 3'b011;
        set_data(0, 9'h055);
        set_data(1, 9'h1AA);
        lcd_wr_done = 1'b1;
        #1;
        chk("t5_cwd", 32'(client_wr_done), 32'h1);
        chk("t5_data", 32'(lcd_data), 32'h055);
        tick();
        lcd_wr_done = 1'b0;
        #1;
        chk("t5_cwd_low", 32'(client_wr_done), 32'd0);
        req_done = 3'b001;
        req_en   = 3'b000;
        tick();
        req_done = 3'b000;
        lcd_wr_done = 1'b1;
        #1;
        chk("t5_gap_cwd", 32'(client_wr_done), 32'd0);
        chk("t5_gap_en", 32'(lcd_en_write), 32'd0);
        tick();
        lcd_wr_done = 1'b0;
        repeat (6) tick();

        // async reset in the middle of a grant
        req_en = 3'b010;
        tick();
        chk("t6_grant", 32'(grant), 32'h2);
        #2;
        sys_rst = 1'b1;
        #1;
        chk("t6_rst_grant", 32'(grant), 32'd0);
        chk("t6_rst_en", 32'(lcd_en_write), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        tick();
        sys_rst = 1'b0;
        req_en  = 3'b111;
        tick();
        chk("t6_first_after_rst", 32'(grant), 32'h1);
        req_en = 3'b000;
        repeat (6) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule
